// File: rtl/conv_tile_scheduler.sv
// Tile/kernel-step sequencer for the PARA_X x PARA_Y conv datapath.
// Walks output tiles in raster order and hands results to the writer.
module conv_tile_scheduler #(
  parameter int PARA_X  = 3,
  parameter int PARA_Y  = 3,
  parameter int KS_W    = 3,
  parameter int DIM_W   = 8,
  parameter int ADDR_W  = 16,
  parameter int WADDR_W = 12
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               start,
  input  logic [KS_W-1:0]    cfg_kernel_size,
  input  logic [DIM_W-1:0]   cfg_fmap_w,
  input  logic [DIM_W-1:0]   cfg_fmap_h,
  input  logic [ADDR_W-1:0]  cfg_fmap_base,
  input  logic [WADDR_W-1:0] cfg_weight_base,
  output logic               busy,
  output logic               done,
  output logic               cfg_err,
  output logic               feed_valid,
  output logic [1:0]         feed_type,
  output logic [ADDR_W-1:0]  fmap_addr,
  output logic [WADDR_W-1:0] weight_addr,
  input  logic               dp_result_ready,
  output logic               wr_valid,
  input  logic               wr_ready,
  output logic [DIM_W-1:0]   wr_tile_row,
  output logic [DIM_W-1:0]   wr_tile_col,
  output logic [KS_W-1:0]    wr_rows,
  output logic [KS_W-1:0]    wr_cols
);

  typedef enum logic [2:0] {
    IDLE, FEED, WAIT, HOLD, DONE
  } state_t;

  state_t st_q, st_n;

  logic [KS_W-1:0]    k_q, k_n;
  logic [DIM_W-1:0]   fw_q, fw_n;
  logic [DIM_W-1:0]   ow_q, ow_n;
  logic [DIM_W-1:0]   oh_q, oh_n;
  logic [ADDR_W-1:0]  fb_q, fb_n;
  logic [WADDR_W-1:0] wb_q, wb_n;
  logic [4:0]         c_q, c_n;
  logic [KS_W-1:0]    kx_q, kx_n;
  logic [KS_W-1:0]    ky_q, ky_n;
  logic [DIM_W-1:0]   row_q, row_n;
  logic [DIM_W-1:0]   col_q, col_n;
  logic               pend_q, pend_n;
  logic               err_n, ld;

  logic               legal, last_tile, free, acc;
  logic [DIM_W-1:0]   row_a, col_a;
  logic [DIM_W-1:0]   rem_r, rem_c;
  logic [KS_W-1:0]    rows_ld, cols_ld;
  logic [ADDR_W-1:0]  fa_n;
  logic [WADDR_W-1:0] wa_n;
  logic [1:0]         ft_n;
  logic               fv_n;

  assign legal = ((cfg_kernel_size == KS_W'(3)) ||
                  (cfg_kernel_size == KS_W'(5))) &&
                 (cfg_fmap_w >= DIM_W'(cfg_kernel_size)) &&
                 (cfg_fmap_h >= DIM_W'(cfg_kernel_size));

  assign last_tile = (col_q + DIM_W'(PARA_Y) >= ow_q) &&
                     (row_q + DIM_W'(PARA_X) >= oh_q);

  assign acc  = wr_valid & wr_ready;
  assign free = ~wr_valid | wr_ready;

  always_comb begin
    row_a = row_q;
    col_a = col_q + DIM_W'(PARA_Y);
    if (col_a >= ow_q) begin
      col_a = '0;
      row_a = row_q + DIM_W'(PARA_X);
    end
  end

  assign rem_r   = oh_q - row_q;
  assign rem_c   = ow_q - col_q;
  assign rows_ld = (rem_r < DIM_W'(PARA_X)) ?
                   KS_W'(rem_r) : KS_W'(PARA_X);
  assign cols_ld = (rem_c < DIM_W'(PARA_Y)) ?
                   KS_W'(rem_c) : KS_W'(PARA_Y);

  always_comb begin
    st_n   = st_q;
    k_n    = k_q;
    fw_n   = fw_q;
    ow_n   = ow_q;
    oh_n   = oh_q;
    fb_n   = fb_q;
    wb_n   = wb_q;
    c_n    = '0;
    kx_n   = '0;
    ky_n   = '0;
    row_n  = row_q;
    col_n  = col_q;
    pend_n = pend_q;
    err_n  = 1'b0;
    ld     = 1'b0;
    unique case (st_q)
      IDLE: begin
        if (start && legal) begin
          k_n   = cfg_kernel_size;
          fw_n  = cfg_fmap_w;
          ow_n  = cfg_fmap_w - DIM_W'(cfg_kernel_size) + DIM_W'(1);
          oh_n  = cfg_fmap_h - DIM_W'(cfg_kernel_size) + DIM_W'(1);
          fb_n  = cfg_fmap_base;
          wb_n  = cfg_weight_base;
          row_n = '0;
          col_n = '0;
          pend_n = 1'b0;
          st_n  = FEED;
        end else if (start) begin
          err_n = 1'b1;
        end
      end
      FEED: begin
        c_n  = c_q + 5'd1;
        kx_n = kx_q + KS_W'(1);
        ky_n = ky_q;
        if (kx_q == k_q - KS_W'(1)) begin
          kx_n = '0;
          ky_n = ky_q + KS_W'(1);
          if (ky_q == k_q - KS_W'(1)) st_n = WAIT;
        end
      end
      WAIT: begin
        if (dp_result_ready && free) begin
          ld    = 1'b1;
          row_n = row_a;
          col_n = col_a;
          st_n  = last_tile ? HOLD : FEED;
        end else if (dp_result_ready) begin
          // Writer still owns the previous tile: park the result.
          pend_n = 1'b1;
          st_n   = HOLD;
        end
      end
      HOLD: begin
        if (acc && pend_q) begin
          ld     = 1'b1;
          pend_n = 1'b0;
          row_n  = row_a;
          col_n  = col_a;
          st_n   = last_tile ? HOLD : FEED;
        end else if (acc) begin
          st_n = (row_q < oh_q) ? FEED : DONE;
        end
      end
      DONE: st_n = IDLE;
      default: st_n = IDLE;
    endcase
  end

  always_comb begin
    fv_n = (st_n == FEED);
    fa_n = '0;
    wa_n = '0;
    ft_n = 2'd0;
    if (fv_n) begin
      fa_n = fb_n +
             (ADDR_W'(row_n) + ADDR_W'(ky_n)) * ADDR_W'(fw_n) +
             ADDR_W'(col_n) + ADDR_W'(kx_n);
      wa_n = wb_n + WADDR_W'(c_n);
      unique case (1'b1)
        (c_n == 5'd0):        ft_n = 2'd0;
        (c_n != 5'd0) && (kx_n == '0): ft_n = 2'd2;
        (kx_n != '0) && (ky_n == '0):  ft_n = 2'd1;
        default:              ft_n = 2'd3;
      endcase
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      st_q        <= IDLE;
      k_q         <= '0;
      fw_q        <= '0;
      ow_q        <= '0;
      oh_q        <= '0;
      fb_q        <= '0;
      wb_q        <= '0;
      c_q         <= '0;
      kx_q        <= '0;
      ky_q        <= '0;
      row_q       <= '0;
      col_q       <= '0;
      pend_q      <= 1'b0;
      cfg_err     <= 1'b0;
      feed_valid  <= 1'b0;
      feed_type   <= '0;
      fmap_addr   <= '0;
      weight_addr <= '0;
      wr_valid    <= 1'b0;
      wr_tile_row <= '0;
      wr_tile_col <= '0;
      wr_rows     <= '0;
      wr_cols     <= '0;
    end else begin
      st_q        <= st_n;
      k_q         <= k_n;
      fw_q        <= fw_n;
      ow_q        <= ow_n;
      oh_q        <= oh_n;
      fb_q        <= fb_n;
      wb_q        <= wb_n;
      c_q         <= c_n;
      kx_q        <= kx_n;
      ky_q        <= ky_n;
      row_q       <= row_n;
      col_q       <= col_n;
      pend_q      <= pend_n;
      cfg_err     <= err_n;
      feed_valid  <= fv_n;
      feed_type   <= ft_n;
      fmap_addr   <= fa_n;
      weight_addr <= wa_n;
      if (ld) begin
        wr_valid    <= 1'b1;
        wr_tile_row <= row_q;
        wr_tile_col <= col_q;
        wr_rows     <= rows_ld;
        wr_cols     <= cols_ld;
      end else if (wr_ready) begin
        wr_valid <= 1'b0;
      end
    end
  end

  assign busy = (st_q != IDLE);
  assign done = (st_q == DONE);

endmodule

// File: tb/tb_conv_tile_scheduler.sv
// Directed bench for conv_tile_scheduler.
// Hand-computed expectations, immediate-assertion checks.
module tb_conv_tile_scheduler;

  logic        clk;
  logic        rst;
  logic        start;
  logic [2:0]  cfg_kernel_size;
  logic [7:0]  cfg_fmap_w;
  logic [7:0]  cfg_fmap_h;
  logic [15:0] cfg_fmap_base;
  logic [11:0] cfg_weight_base;
  logic        busy;
  logic        done;
  logic        cfg_err;
  logic        feed_valid;
  logic [1:0]  feed_type;
  logic [15:0] fmap_addr;
  logic [11:0] weight_addr;
  logic        dp_result_ready;
  logic        wr_valid;
  logic        wr_ready;
  logic [7:0]  wr_tile_row;
  logic [7:0]  wr_tile_col;
  logic [2:0]  wr_rows;
  logic [2:0]  wr_cols;

  int checks = 0;
  int errors = 0;

  conv_tile_scheduler dut (
    .clk             (clk),
    .rst             (rst),
    .start           (start),
    .cfg_kernel_size (cfg_kernel_size),
    .cfg_fmap_w      (cfg_fmap_w),
    .cfg_fmap_h      (cfg_fmap_h),
    .cfg_fmap_base   (cfg_fmap_base),
    .cfg_weight_base (cfg_weight_base),
    .busy            (busy),
    .done            (done),
    .cfg_err         (cfg_err),
    .feed_valid      (feed_valid),
    .feed_type       (feed_type),
    .fmap_addr       (fmap_addr),
    .weight_addr     (weight_addr),
    .dp_result_ready (dp_result_ready),
    .wr_valid        (wr_valid),
    .wr_ready        (wr_ready),
    .wr_tile_row     (wr_tile_row),
    .wr_tile_col     (wr_tile_col),
    .wr_rows         (wr_rows),
    .wr_cols         (wr_cols)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag,
                     input logic [31:0] obs,
                     input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  function automatic int ftype(input int c, input int k);
    if (c == 0) return 0;
    if (c % k == 0) return 2;
    if (c < k) return 1;
    return 3;
  endfunction

  task automatic set_cfg(input int k, input int w, input int h,
                         input int fb, input int wb);
    cfg_kernel_size = 3'(k);
    cfg_fmap_w      = 8'(w);
    cfg_fmap_h      = 8'(h);
    cfg_fmap_base   = 16'(fb);
    cfg_weight_base = 12'(wb);
  endtask

  int er [4] = '{0, 0, 3, 3};
  int ec [4] = '{0, 3, 0, 3};
  int erw[4] = '{3, 3, 2, 2};
  int ecl[4] = '{3, 2, 3, 2};

  initial begin
    rst = 1'b0;
    start = 1'b0;
    dp_result_ready = 1'b0;
    wr_ready = 1'b0;
    set_cfg(3, 5, 5, 0, 0);
    #12;
    chk("rst_busy", 32'(busy), 0);
    chk("rst_done", 32'(done), 0);
    chk("rst_err", 32'(cfg_err), 0);
    chk("rst_fv", 32'(feed_valid), 0);
    chk("rst_wv", 32'(wr_valid), 0);
    chk("rst_faddr", 32'(fmap_addr), 0);
    chk("rst_waddr", 32'(weight_addr), 0);
    chk("rst_wrow", 32'(wr_tile_row), 0);
    rst = 1'b1;
    tick();

    // single tile, K=3, 5x5
    set_cfg(3, 5, 5, 'h100, 'h010);
    start = 1'b1;
    tick();
    start = 1'b0;
    chk("t1_busy", 32'(busy), 1);
    for (int c = 0; c < 9; c++) begin
      chk("t1_fv", 32'(feed_valid), 1);
      chk("t1_type", 32'(feed_type), 32'(ftype(c, 3)));
      chk("t1_waddr", 32'(weight_addr), 32'('h10 + c));
      chk("t1_faddr", 32'(fmap_addr),
          32'('h100 + (c / 3) * 5 + c % 3));
      tick();
    end
    chk("t1_fv_end", 32'(feed_valid), 0);
    tick();
    dp_result_ready = 1'b1;
    wr_ready = 1'b1;
    tick();
    dp_result_ready = 1'b0;
    chk("t1_wv", 32'(wr_valid), 1);
    chk("t1_rows", 32'(wr_rows), 3);
    chk("t1_cols", 32'(wr_cols), 3);
    chk("t1_tile", 32'({wr_tile_row, wr_tile_col}), 0);
    tick();
    chk("t1_done", 32'(done), 1);
    chk("t1_wv_clr", 32'(wr_valid), 0);
    tick();
    chk("t1_done_once", 32'(done), 0);
    chk("t1_idle", 32'(busy), 0);
    tick();
    chk("t1_done_quiet", 32'(done), 0);

    // four tiles with clipping, K=5, 9x9
    set_cfg(5, 9, 9, 'h200, 'h040);
    start = 1'b1;
    tick();
    start = 1'b0;
    for (int t = 0; t < 4; t++) begin
      for (int c = 0; c < 25; c++) begin
        chk("t2_fv", 32'(feed_valid), 1);
        chk("t2_type", 32'(feed_type), 32'(ftype(c, 5)));
        chk("t2_waddr", 32'(weight_addr), 32'('h40 + c));
        chk("t2_faddr", 32'(fmap_addr),
            32'('h200 + (er[t] + c / 5) * 9 + ec[t] + c % 5));
        if (t == 1 && c == 6)
          chk("t2_faddr_c6", 32'(fmap_addr), 32'h20d);
        tick();
      end
      chk("t2_fv_end", 32'(feed_valid), 0);
      dp_result_ready = 1'b1;
      tick();
      dp_result_ready = 1'b0;
      chk("t2_wv", 32'(wr_valid), 1);
      chk("t2_row", 32'(wr_tile_row), 32'(er[t]));
      chk("t2_col", 32'(wr_tile_col), 32'(ec[t]));
      chk("t2_rows", 32'(wr_rows), 32'(erw[t]));
      chk("t2_cols", 32'(wr_cols), 32'(ecl[t]));
    end
    tick();
    chk("t2_done", 32'(done), 1);
    tick();
    chk("t2_done_once", 32'(done), 0);
    chk("t2_idle", 32'(busy), 0);

    // backpressure: two tiles, K=3, 8x5
    wr_ready = 1'b0;
    set_cfg(3, 8, 5, 0, 0);
    start = 1'b1;
    tick();
    start = 1'b0;
    repeat (9) tick();
    dp_result_ready = 1'b1;
    tick();
    dp_result_ready = 1'b0;
    chk("t3_wv0", 32'(wr_valid), 1);
    for (int c = 0; c < 9; c++) begin
      chk("t3_fv1", 32'(feed_valid), 1);
      chk("t3_faddr1", 32'(fmap_addr), 32'((c / 3) * 8 + 3 + c % 3));
      chk("t3_col_feed", 32'(wr_tile_col), 0);
      tick();
    end
    tick();
    dp_result_ready = 1'b1;
    tick();
    dp_result_ready = 1'b0;
    for (int i = 0; i < 20; i++) begin
      chk("t3_hold_wv", 32'(wr_valid), 1);
      chk("t3_hold_col", 32'(wr_tile_col), 0);
      chk("t3_hold_fv", 32'(feed_valid), 0);
      chk("t3_hold_busy", 32'(busy), 1);
      tick();
    end
    wr_ready = 1'b1;
    tick();
    chk("t3_wv1", 32'(wr_valid), 1);
    chk("t3_col1", 32'(wr_tile_col), 3);
    chk("t3_cols1", 32'(wr_cols), 3);
    chk("t3_rows1", 32'(wr_rows), 3);
    tick();
    chk("t3_done", 32'(done), 1);
    wr_ready = 1'b0;
    tick();
    chk("t3_idle", 32'(busy), 0);

    // illegal configs and start while busy
    set_cfg(4, 5, 5, 0, 0);
    start = 1'b1;
    tick();
    start = 1'b0;
    chk("t4_err_k4", 32'(cfg_err), 1);
    chk("t4_busy_k4", 32'(busy), 0);
    tick();
    chk("t4_err_pulse", 32'(cfg_err), 0);
    set_cfg(3, 2, 5, 0, 0);
    start = 1'b1;
    tick();
    start = 1'b0;
    chk("t4_err_w2", 32'(cfg_err), 1);
    chk("t4_busy_w2", 32'(busy), 0);
    set_cfg(3, 5, 5, 0, 'h030);
    start = 1'b1;
    tick();
    chk("t4_busy", 32'(busy), 1);
    chk("t4_w0", 32'(weight_addr), 32'h30);
    set_cfg(4, 5, 5, 0, 0);
    tick();
    start = 1'b0;
    chk("t4_ign_err", 32'(cfg_err), 0);
    chk("t4_ign_fv", 32'(feed_valid), 1);
    chk("t4_ign_w1", 32'(weight_addr), 32'h31);
    set_cfg(3, 5, 5, 0, 0);
    repeat (3) tick();
    chk("t5_c4_w", 32'(weight_addr), 32'h34);
    chk("t5_c4_f", 32'(fmap_addr), 6);

    // asynchronous reset mid-feed
    #2;
    rst = 1'b0;
    #1;
    chk("t5_rst_fv", 32'(feed_valid), 0);
    chk("t5_rst_busy", 32'(busy), 0);
    chk("t5_rst_w", 32'(weight_addr), 0);
    chk("t5_rst_f", 32'(fmap_addr), 0);
    chk("t5_rst_type", 32'(feed_type), 0);
    #2;
    rst = 1'b1;
    tick();

    // restart, then same-cycle accept/load
    set_cfg(3, 8, 5, 'h300, 'h020);
    start = 1'b1;
    tick();
    start = 1'b0;
    chk("t5_re_fv", 32'(feed_valid), 1);
    chk("t5_re_type", 32'(feed_type), 0);
    chk("t5_re_w", 32'(weight_addr), 32'h20);
    chk("t5_re_f", 32'(fmap_addr), 32'h300);
    repeat (9) tick();
    dp_result_ready = 1'b1;
    tick();
    dp_result_ready = 1'b0;
    chk("t6_wv0", 32'(wr_valid), 1);
    chk("t6_f1", 32'(fmap_addr), 32'h303);
    repeat (9) tick();
    chk("t6_wv_wait", 32'(wr_valid), 1);
    chk("t6_col_wait", 32'(wr_tile_col), 0);
    dp_result_ready = 1'b1;
    wr_ready = 1'b1;
    tick();
    dp_result_ready = 1'b0;
    chk("t6_wv_nobub", 32'(wr_valid), 1);
    chk("t6_col_new", 32'(wr_tile_col), 3);
    chk("t6_row_new", 32'(wr_tile_row), 0);
    tick();
    chk("t6_done", 32'(done), 1);
    chk("t6_wv_clr", 32'(wr_valid), 0);
    wr_ready = 1'b0;
    tick();
    chk("t6_idle", 32'(busy), 0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
